shreg_mc: RTL and testbench

- Multi-channel, lane-unrolled tapped shift register for the receive datapath.
- Each clock, every channel accepts up to UNR new samples and exposes the last BUFLEN samples as a parallel tap window for the downstream unrolled FIR/correlator.
- It extends the single-channel fixed-shift register with:
  - NCH channels sharing one shift control;
  - a variable per-cycle shift count;
  - a valid qualifier, a synchronous clear, and a fill counter that flags when the window holds only fresh data.

---
 rtl/shreg_mc.sv | 109 ++++++++++
 tb/tb_shreg_mc.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/shreg_mc.sv
// Multi-channel, lane-unrolled tapped shift register with variable shift count,
// valid qualifier, synchronous clear and fill counter. Macro SHREG_MC_OUTREG_EN adds an output register stage.
module shreg_mc #(
  parameter int DWIDTH = 14,
  parameter int UNR    = 4,
  parameter int BUFLEN = 40,
  parameter int NCH    = 2,
  localparam int CW    = $clog2(BUFLEN + 1),
  localparam int NW    = $clog2(UNR + 1)
) (
  input  logic                                   CLK,
  input  logic                                   RST_N,
  input  logic                                   clr,
  input  logic                                   din_valid,
  input  logic [NW-1:0]                          nlanes,
  input  logic [NCH-1:0][UNR-1:0][DWIDTH-1:0]    din,
  output logic [NCH-1:0][BUFLEN-1:0][DWIDTH-1:0] dout,
  output logic [CW-1:0]                          fill_cnt,
  output logic                                   full,
  output logic                                   dout_upd
);

  logic [NCH-1:0][BUFLEN-1:0][DWIDTH-1:0]        win;
  logic [UNR:0][NCH-1:0][BUFLEN-1:0][DWIDTH-1:0] cand;
  logic [CW-1:0]                                 fill_r;
  logic [CW-1:0]                                 fill_nxt;
  logic [CW:0]                                   fill_sum;
  logic                                          full_r;
  logic                                          upd_r;
  logic [NW-1:0]                                 n;

  always_comb begin
    n = '0;
    if (din_valid && !clr) begin
      n = (nlanes > NW'(UNR)) ? NW'(UNR) : nlanes;
    end
  end

  // One precomputed window per possible shift count; n then selects among them.
  assign cand[0] = win;
  for (genvar k = 1; k <= UNR; k++) begin : g_shift
    for (genvar c = 0; c < NCH; c++) begin : g_ch
      for (genvar j = 0; j < BUFLEN; j++) begin : g_tap
        if (j < k) begin : g_new
          assign cand[k][c][j] = din[c][k-1-j];
        end else begin : g_old
          assign cand[k][c][j] = win[c][j-k];
        end
      end
    end
  end

  always_comb begin
    fill_sum = {1'b0, fill_r} + (CW+1)'(n);
    fill_nxt = fill_sum[CW-1:0];
    if (fill_sum >= (CW+1)'(BUFLEN)) begin
      fill_nxt = CW'(BUFLEN);
    end
    if (clr) begin
      fill_nxt = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      win    <= '0;
      fill_r <= '0;
      full_r <= 1'b0;
      upd_r  <= 1'b0;
    end else begin
      win    <= clr ? '0 : cand[n];
      fill_r <= fill_nxt;
      full_r <= (fill_nxt == CW'(BUFLEN));
      upd_r  <= clr || (n != '0);
    end
  end

`ifdef SHREG_MC_OUTREG_EN
  logic [NCH-1:0][BUFLEN-1:0][DWIDTH-1:0] dout_q;
  logic [CW-1:0]                          fill_q;
  logic                                   full_q;
  logic                                   upd_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dout_q <= '0;
      fill_q <= '0;
      full_q <= 1'b0;
      upd_q  <= 1'b0;
    end else begin
      dout_q <= win;
      fill_q <= fill_r;
      full_q <= full_r;
      upd_q  <= upd_r;
    end
  end

  assign dout     = dout_q;
  assign fill_cnt = fill_q;
  assign full     = full_q;
  assign dout_upd = upd_q;
`else
  assign dout     = win;
  assign fill_cnt = fill_r;
  assign full     = full_r;
  assign dout_upd = upd_r;
`endif

endmodule

// File: tb/tb_shreg_mc.sv
// Directed, table-driven bench for shreg_mc; expected values are hand-derived.
module tb_shreg_mc;
  localparam int DWIDTH = 14;
  localparam int UNR    = 4;
  localparam int BUFLEN = 40;
  localparam int NCH    = 2;
  localparam int CW     = $clog2(BUFLEN + 1);
  localparam int NW     = $clog2(UNR + 1);
`ifdef SHREG_MC_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                                   CLK;
  logic                                   RST_N;
  logic                                   clr;
  logic                                   din_valid;
  logic [NW-1:0]                          nlanes;
  logic [NCH-1:0][UNR-1:0][DWIDTH-1:0]    din;
  logic [NCH-1:0][BUFLEN-1:0][DWIDTH-1:0] dout;
  logic [CW-1:0]                          fill_cnt;
  logic                                   full;
  logic                                   dout_upd;

  int n_chk = 0;
  int n_fail = 0;

  shreg_mc #(.DWIDTH(DWIDTH), .UNR(UNR), .BUFLEN(BUFLEN), .NCH(NCH)) dut (
    .CLK(CLK), .RST_N(RST_N), .clr(clr), .din_valid(din_valid), .nlanes(nlanes),
    .din(din), .dout(dout), .fill_cnt(fill_cnt), .full(full), .dout_upd(dout_upd)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic v;
    int   nl;
    int   d[4];
    int   efill;
    int   etap[5];
    logic eupd;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic c, input int nl,
                       input int a0, input int a1, input int a2, input int a3);
    din_valid = v;
    clr       = c;
    nlanes    = NW'(nl);
    din[0][0] = DWIDTH'(a0);       din[0][1] = DWIDTH'(a1);
    din[0][2] = DWIDTH'(a2);       din[0][3] = DWIDTH'(a3);
    din[1][0] = DWIDTH'(a0 + 100); din[1][1] = DWIDTH'(a1 + 100);
    din[1][2] = DWIDTH'(a2 + 100); din[1][3] = DWIDTH'(a3 + 100);
  endtask

  task automatic push(input logic v, input logic c, input int nl,
                      input int a0, input int a1, input int a2, input int a3);
    drive(v, c, nl, a0, a1, a2, a3);
    cyc();
  endtask

  // Idle cycles so that the outputs reflect the last accepting edge.
  task automatic settle();
    din_valid = 1'b0;
    clr       = 1'b0;
    repeat (LAT - 1) cyc();
  endtask

  task automatic chk_clear(input string nm, input int eupd);
    chk({nm, "_dout_zero"}, int'(dout != '0), 0);
    chk({nm, "_fill"}, int'(fill_cnt), 0);
    chk({nm, "_full"}, int'(full), 0);
    chk({nm, "_upd"}, int'(dout_upd), eupd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[6];
    int   fs[11];
    int   fl[11];
    int   ucount;
    int   e;

    vt[0] = '{1'b1, 2, '{1, 2, 3, 4},       2, '{2, 1, 0, 0, 0},    1'b1};
    vt[1] = '{1'b1, 3, '{5, 6, 7, 8},       5, '{7, 6, 5, 2, 1},    1'b1};
    vt[2] = '{1'b1, 7, '{9, 10, 11, 12},    9, '{12, 11, 10, 9, 7}, 1'b1};
    vt[3] = '{1'b0, 4, '{20, 21, 22, 23},   9, '{12, 11, 10, 9, 7}, 1'b0};
    vt[4] = '{1'b1, 0, '{30, 31, 32, 33},   9, '{12, 11, 10, 9, 7}, 1'b0};
    vt[5] = '{1'b1, 1, '{13, 99, 99, 99},  10, '{13, 12, 11, 10, 9}, 1'b1};

    RST_N = 1'b0;
    drive(1'b0, 1'b0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge CLK);
    #1;
    chk_clear("reset", 0);
    RST_N = 1'b1;

    for (int i = 0; i < 10; i++) begin
      cyc();
      chk_clear("idle", 0);
    end

    // Full-width stream, outputs recorded per cycle.
    ucount = 0;
    for (int i = 0; i < 10; i++) begin
      push(1'b1, 1'b0, 4, 4*i+1, 4*i+2, 4*i+3, 4*i+4);
      fs[i] = int'(fill_cnt);
      fl[i] = int'(full);
      ucount += int'(dout_upd);
    end
    din_valid = 1'b0;
    for (int i = 0; i < LAT - 1; i++) begin
      cyc();
      fs[10+i] = int'(fill_cnt);
      fl[10+i] = int'(full);
      ucount += int'(dout_upd);
    end
    for (int i = 0; i < 9 + LAT; i++) begin
      e = i + 1 - (LAT - 1);
      chk("stream_fill", fs[i], 4*e);
      chk("stream_full", fl[i], int'(e == 10));
    end
    chk("stream_upd_count", ucount, 10);
    chk("stream_t0",  int'(dout[0][0]), 40);
    chk("stream_t1",  int'(dout[0][1]), 39);
    chk("stream_t2",  int'(dout[0][2]), 38);
    chk("stream_t3",  int'(dout[0][3]), 37);
    chk("stream_t39", int'(dout[0][39]), 1);
    chk("stream_c1t0", int'(dout[1][0]), 140);
    chk("stream_c1t39", int'(dout[1][39]), 101);

    // Saturation: keep shifting past full.
    push(1'b1, 1'b0, 4, 41, 42, 43, 44);
    push(1'b1, 1'b0, 4, 45, 46, 47, 48);
    settle();
    chk("sat_fill", int'(fill_cnt), 40);
    chk("sat_full", int'(full), 1);
    chk("sat_t0",  int'(dout[0][0]), 48);
    chk("sat_t3",  int'(dout[0][3]), 45);
    chk("sat_t39", int'(dout[0][39]), 9);
    chk("sat_c1t0", int'(dout[1][0]), 148);

    // clr wins over same-cycle valid data.
    push(1'b1, 1'b1, 4, 50, 51, 52, 53);
    settle();
    chk_clear("clr", 1);
    cyc();
    chk_clear("clr_after", 0);
    push(1'b0, 1'b1, 0, 0, 0, 0, 0);
    settle();
    chk_clear("clr_again", 1);
    cyc();

    // Partial lanes, clamping and holds.
    for (int i = 0; i < 6; i++) begin
      push(vt[i].v, 1'b0, vt[i].nl, vt[i].d[0], vt[i].d[1], vt[i].d[2], vt[i].d[3]);
      settle();
      chk($sformatf("part%0d_fill", i), int'(fill_cnt), vt[i].efill);
      chk($sformatf("part%0d_upd", i), int'(dout_upd), int'(vt[i].eupd));
      for (int j = 0; j < 5; j++)
        chk($sformatf("part%0d_t%0d", i, j), int'(dout[0][j]), vt[i].etap[j]);
      chk($sformatf("part%0d_c1t0", i), int'(dout[1][0]),
          (vt[i].etap[0] == 0) ? 0 : vt[i].etap[0] + 100);
    end

    // Asynchronous reset between edges.
    push(1'b0, 1'b1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      push(1'b1, 1'b0, 4, 4*i+1, 4*i+2, 4*i+3, 4*i+4);
    settle();
    chk("pre_rst_fill", int'(fill_cnt), 20);
    #2;
    RST_N = 1'b0;
    #1;
    chk_clear("async_rst", 0);
    cyc();
    RST_N = 1'b1;
    push(1'b1, 1'b0, 4, 1, 2, 3, 4);
    din_valid = 1'b0;
    chk("post_rst_lat_fill", int'(fill_cnt), (LAT == 1) ? 4 : 0);
    settle();
    chk("post_rst_fill", int'(fill_cnt), 4);
    chk("post_rst_full", int'(full), 0);
    chk("post_rst_t0", int'(dout[0][0]), 4);
    chk("post_rst_t3", int'(dout[0][3]), 1);
    chk("post_rst_t4", int'(dout[0][4]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
